// File: rtl/bios_loader_pkg.sv
// Shared types and defaults for the BIOS download loader.
package bios_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    XFER,
    DONE
  } drain_state_e;

  localparam int          BLK_WORDS_DEF = 64;
  localparam logic [15:0] FILL_WORD_DEF = 16'hFFFF;

endpackage

// File: rtl/bios_pingpong_buf.sv
// Two-bank word buffer with per-bank full flag / fill count and a registered read
// port that substitutes FILL_WORD past the end of a partially filled bank.
module bios_pingpong_buf #(
  parameter int          BLK_WORDS = 64,
  parameter logic [15:0] FILL_WORD = 16'hFFFF,
  localparam int         IW        = $clog2(BLK_WORDS),
  localparam int         CW        = IW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          we_i,
  input  logic          wbank_i,
  input  logic [IW-1:0] widx_i,
  input  logic [15:0]   wdata_i,
  input  logic          commit_i,
  input  logic          cbank_i,
  input  logic [CW-1:0] ccount_i,
  input  logic          free_i,
  input  logic          fbank_i,
  input  logic          re_i,
  input  logic          rbank_i,
  input  logic [IW-1:0] ridx_i,
  output logic [15:0]   rdata_o,
  output logic [1:0]    full_o
);

  logic [15:0]         mem [2*BLK_WORDS];
  logic [1:0][CW-1:0]  cnt_q;
  logic [1:0]          full_q;
  logic [15:0]         rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[{wbank_i, widx_i}] <= wdata_i;
  end

  // Commit is applied after free so a bank freed and refilled in one cycle ends full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (clear_i) begin
        full_q <= '0;
        cnt_q  <= '0;
      end
      if (free_i) full_q[fbank_i] <= 1'b0;
      if (commit_i) begin
        full_q[cbank_i] <= 1'b1;
        cnt_q[cbank_i]  <= ccount_i;
      end
      if (re_i)
        rdata_q <= ({1'b0, ridx_i} < cnt_q[rbank_i]) ? mem[{rbank_i, ridx_i}] : FILL_WORD;
    end
  end

  assign rdata_o = rdata_q;
  assign full_o  = full_q;

endmodule

// File: rtl/bios_loader.sv
// Packs the data_io byte stream into 16-bit words, buffers them in ping-pong banks
// and hands each bank to the BIOS port. Optional checksum: BIOS_LOADER_CHECKSUM_EN.
module bios_loader
  import bios_loader_pkg::*;
#(
  parameter int          BLK_WORDS  = BLK_WORDS_DEF,
  parameter int          ADDR_W     = 13,
  parameter logic [7:0]  BIOS_INDEX = 8'h00,
  parameter logic [15:0] FILL_WORD  = FILL_WORD_DEF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              bios_req,
  output logic              bios_wr,
  output logic [ADDR_W-1:0] bios_addr,
  output logic [15:0]       bios_din,
  output logic              bios_loaded,
  output logic              overrun,
  output logic [15:0]       checksum
);

  localparam int IW = $clog2(BLK_WORDS);
  localparam int CW = IW + 1;

  drain_state_e      state_q;
  logic              active_q, end_seen_q, loaded_q, overrun_q, bios_wr_q;
  logic              fill_bank_q, drain_bank_q, lo_vld_q;
  logic [7:0]        lo_q;
  logic [IW-1:0]     wp_q, rp_q;
  logic [ADDR_W-1:0] bios_addr_q;

  logic          active, start, stop, free_now, hi_wr, lo_wr, busy, word_ev;
  logic          word_we, word_drop, commit, fb;
  logic [IW-1:0] wp_b;
  logic [CW-1:0] cnt;
  logic [15:0]   word_d;
  logic [1:0]    full;
  logic          unused_addr;

  assign unused_addr = ^ioctl_addr[24:1];

  assign active   = ioctl_download && (ioctl_index == BIOS_INDEX);
  assign start    = active && !active_q;
  assign stop     = !active && active_q;
  assign free_now = (state_q == DONE);

  // A strobe on the first active cycle targets the freshly cleared bank 0.
  always_comb begin
    fb        = start ? 1'b0 : fill_bank_q;
    wp_b      = start ? '0 : wp_q;
    hi_wr     = active && ioctl_wr && ioctl_addr[0];
    lo_wr     = active && ioctl_wr && !ioctl_addr[0];
    busy      = !start && full[fb] && !(free_now && (drain_bank_q == fb));
    word_ev   = hi_wr || (stop && lo_vld_q);
    word_d    = hi_wr ? {ioctl_dout, lo_q} : {8'h00, lo_q};
    word_we   = word_ev && !busy;
    word_drop = word_ev && busy;
    cnt       = {1'b0, wp_b} + CW'(word_we);
    commit    = (word_we && (wp_b == IW'(BLK_WORDS - 1))) || (stop && (cnt != '0));
  end

  bios_pingpong_buf #(
    .BLK_WORDS(BLK_WORDS),
    .FILL_WORD(FILL_WORD)
  ) u_buf (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .clear_i (start),
    .we_i    (word_we),
    .wbank_i (fb),
    .widx_i  (wp_b),
    .wdata_i (word_d),
    .commit_i(commit),
    .cbank_i (fb),
    .ccount_i(cnt),
    .free_i  (free_now),
    .fbank_i (drain_bank_q),
    .re_i    ((state_q == XFER) && bios_req),
    .rbank_i (drain_bank_q),
    .ridx_i  (rp_q),
    .rdata_o (bios_din),
    .full_o  (full)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      active_q     <= 1'b0;
      end_seen_q   <= 1'b0;
      loaded_q     <= 1'b0;
      overrun_q    <= 1'b0;
      bios_wr_q    <= 1'b0;
      fill_bank_q  <= 1'b0;
      drain_bank_q <= 1'b0;
      lo_vld_q     <= 1'b0;
      lo_q         <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      bios_addr_q  <= '0;
    end else begin
      active_q <= active;
      if (start) begin
        state_q      <= IDLE;
        end_seen_q   <= 1'b0;
        loaded_q     <= 1'b0;
        overrun_q    <= 1'b0;
        bios_wr_q    <= 1'b0;
        fill_bank_q  <= 1'b0;
        drain_bank_q <= 1'b0;
        lo_vld_q     <= 1'b0;
        wp_q         <= '0;
        bios_addr_q  <= '0;
      end
      if (lo_wr) begin
        lo_q     <= ioctl_dout;
        lo_vld_q <= 1'b1;
      end
      if (hi_wr || stop) lo_vld_q <= 1'b0;
      if (word_drop) overrun_q <= 1'b1;
      if (word_we) wp_q <= wp_b + IW'(1);
      if (commit) begin
        wp_q        <= '0;
        fill_bank_q <= ~fb;
      end
      if (stop) end_seen_q <= 1'b1;
      if (!start && end_seen_q && (full == 2'b00) && (state_q == IDLE)) loaded_q <= 1'b1;
      if (!start) begin
        unique case (state_q)
          IDLE: if (full[drain_bank_q]) begin
            state_q   <= READY;
            bios_wr_q <= 1'b1;
            rp_q      <= '0;
          end
          READY: if (bios_req) state_q <= XFER;
          XFER: begin
            if (bios_req) begin
              bios_addr_q <= bios_addr_q + ADDR_W'(1);
              rp_q        <= rp_q + IW'(1);
            end else begin
              state_q <= DONE;
            end
          end
          DONE: begin
            bios_wr_q    <= 1'b0;
            drain_bank_q <= ~drain_bank_q;
            state_q      <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [15:0] csum_q;
  always_ff @(posedge clk_sys) begin
    if (reset) csum_q <= '0;
    else if (start || word_we) csum_q <= (start ? 16'h0 : csum_q) + (word_we ? word_d : 16'h0);
  end
  assign checksum = csum_q;
`else
  assign checksum = 16'h0;
`endif

  assign bios_wr     = bios_wr_q;
  assign bios_addr   = bios_addr_q;
  assign bios_loaded = loaded_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_bios_loader.sv
// Table-driven download scenarios with a word scoreboard fed by a byte-level model.
module tb_bios_loader;

  localparam int          BLK      = 64;
  localparam logic [7:0]  BIOS_IDX = 8'h00;
  localparam logic [15:0] FILLW    = 16'hFFFF;

  logic        clk_sys = 1'b0;
  logic        reset, ioctl_download, ioctl_wr, bios_req;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        bios_wr, bios_loaded, overrun;
  logic [12:0] bios_addr;
  logic [15:0] bios_din, checksum;

  bios_loader dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .bios_req      (bios_req),
    .bios_wr       (bios_wr),
    .bios_addr     (bios_addr),
    .bios_din      (bios_din),
    .bios_loaded   (bios_loaded),
    .overrun       (overrun),
    .checksum      (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string      name;
    logic [7:0] idx;
    int         nbytes;
    logic [7:0] base;
    logic [7:0] step;
    int         exp_banks;
    logic       exp_ovr;
    logic       exp_loaded;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] exp_q[$];
  logic [15:0] last_csum = 16'h0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_wr(input logic val, input string nm);
    int n = 0;
    while (bios_wr !== val && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check(nm, 32'(bios_wr), 32'(val));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wr"}, 32'(bios_wr), 0);
    check({tag, "_addr"}, 32'(bios_addr), 0);
    check({tag, "_din"}, 32'(bios_din), 0);
    check({tag, "_loaded"}, 32'(bios_loaded), 0);
    check({tag, "_ovr"}, 32'(overrun), 0);
    check({tag, "_csum"}, 32'(checksum), 0);
  endtask

  // Sends the byte stream and pushes each word the DUT should accept; nothing is
  // drained during a download, so only the first two banks' worth is accepted.
  task automatic run_download(input vec_t v, output logic [15:0] csum);
    logic [7:0]  b, lo;
    logic [15:0] w;
    int          nacc;
    bit          match;
    match = (v.idx == BIOS_IDX);
    nacc  = 0;
    csum  = 16'h0;
    lo    = 8'h00;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    ioctl_index    = v.idx;
    for (int i = 0; i < v.nbytes; i++) begin
      b = 8'(int'(v.base) + int'(v.step) * i);
      @(negedge clk_sys);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = b;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      if (i % 2 == 0) lo = b;
      else if (match && nacc < 2 * BLK) begin
        w = {b, lo};
        exp_q.push_back(w);
        csum = csum + w;
        nacc++;
      end
    end
    if (match && (v.nbytes % 2 == 1) && nacc < 2 * BLK) begin
      w = {8'h00, lo};
      exp_q.push_back(w);
      csum = csum + w;
      nacc++;
    end
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    while (match && (nacc % BLK) != 0) begin
      exp_q.push_back(FILLW);
      nacc++;
    end
  endtask

  // System side: one request cycle to enter XFER, then one word per request cycle.
  task automatic drain(input int abort_at);
    logic [15:0] e;
    wait_wr(1'b1, "wr_rise");
    bios_req = 1'b1;
    @(negedge clk_sys);
    for (int k = 0; k < BLK; k++) begin
      @(negedge clk_sys);
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        check($sformatf("din_w%0d", k), 32'(bios_din), 32'(e));
      end
      if (k == abort_at) begin
        reset    = 1'b1;
        bios_req = 1'b0;
        @(negedge clk_sys);
        check_reset_state("abort");
        reset = 1'b0;
        return;
      end
    end
    bios_req = 1'b0;
    wait_wr(1'b0, "wr_fall");
  endtask

  task automatic apply(input vec_t v);
    logic [12:0] addr0;
    logic [15:0] csum, exp_csum;
    bit          match;
    int          n;
    match = (v.idx == BIOS_IDX);
    addr0 = bios_addr;
    run_download(v, csum);
    repeat (3) @(negedge clk_sys);
    check({v.name, "_overrun"}, 32'(overrun), 32'(v.exp_ovr));
    check({v.name, "_wr_pending"}, 32'(bios_wr), 32'(v.exp_banks > 0));
    if (v.exp_banks > 0) check({v.name, "_loaded_early"}, 32'(bios_loaded), 0);
    for (int b = 0; b < v.exp_banks; b++) drain(-1);
    if (!match) begin
      bios_req = 1'b1;
      repeat (3) @(negedge clk_sys);
      check({v.name, "_req_in_idle"}, 32'(bios_wr), 0);
      bios_req = 1'b0;
    end
    n = 0;
    while (bios_loaded !== v.exp_loaded && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    check({v.name, "_loaded"}, 32'(bios_loaded), 32'(v.exp_loaded));
    check({v.name, "_addr"}, 32'(bios_addr), match ? 32'(13'(v.exp_banks * BLK)) : 32'(addr0));
    if (match) last_csum = csum;
`ifdef BIOS_LOADER_CHECKSUM_EN
    exp_csum = last_csum;
`else
    exp_csum = 16'h0;
`endif
    check({v.name, "_checksum"}, 32'(checksum), 32'(exp_csum));
    check({v.name, "_sb_left"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    logic [15:0] dummy;
    vecs[0] = '{"full2",    8'h00, 256, 8'h00, 8'h01, 2, 1'b0, 1'b1};
    vecs[1] = '{"partial5", 8'h00,   5, 8'hAA, 8'h11, 1, 1'b0, 1'b1};
    vecs[2] = '{"overrun",  8'h00, 320, 8'h03, 8'h07, 2, 1'b1, 1'b1};
    vecs[3] = '{"odd131",   8'h00, 131, 8'h40, 8'h05, 2, 1'b0, 1'b1};
    vecs[4] = '{"wrongidx", 8'h01,  10, 8'h10, 8'h01, 0, 1'b0, 1'b1};

    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    bios_req       = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) apply(vecs[i]);

    // Reset during the first bank's transfer, then a clean repeat of the full image.
    run_download(vecs[0], dummy);
    drain(20);
    exp_q.delete();
    apply(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
